// File: rtl/stopwatch_ctrl.sv
// MM:SS stopwatch controller: run/hold/adjust modes, pause toggle latch,
// and blink-driven blanking of the field being adjusted.
module stopwatch_ctrl #(
    parameter int MIN_MAX = 99,
    parameter int MIN_W   = 7,
    parameter int SEC_MAX = 59,
    parameter int SEC_W   = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_1hz,
    input  logic             tick_2hz,
    input  logic             tick_blink,
    input  logic             sel,
    input  logic             adj,
    input  logic             pause,
    output logic [MIN_W-1:0] minutes,
    output logic [SEC_W-1:0] seconds,
    output logic             blank_min,
    output logic             blank_sec,
    output logic             rollover,
    output logic [1:0]       mode
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_HOLD = 2'b01,
        ST_ADJ  = 2'b10
    } state_t;

    localparam logic [MIN_W-1:0] MIN_MAX_V = MIN_W'(MIN_MAX);
    localparam logic [SEC_W-1:0] SEC_MAX_V = SEC_W'(SEC_MAX);

    state_t           state_q, state_d;
    logic [MIN_W-1:0] min_q, min_d;
    logic [SEC_W-1:0] sec_q, sec_d;
    logic             rollover_q, rollover_d;
    logic             pause_prev_q, pause_prev_d;
    logic             paused_q, paused_d;
    logic             blink_q, blink_d;
    logic             pause_rise_s;
    logic             min_wrap_s;
    logic             sec_wrap_s;

    // Next-state, counter and blink-phase logic; actions use the registered state.
    always_comb begin
        pause_rise_s = pause & ~pause_prev_q;
        pause_prev_d = pause;
        paused_d     = paused_q ^ pause_rise_s;
        min_wrap_s   = (min_q >= MIN_MAX_V);
        sec_wrap_s   = (sec_q >= SEC_MAX_V);
        min_d        = min_q;
        sec_d        = sec_q;
        rollover_d   = 1'b0;

        if (paused_q) begin
            state_d = ST_HOLD;
        end else if (adj) begin
            state_d = ST_ADJ;
        end else begin
            state_d = ST_RUN;
        end

        case (state_q)
            ST_RUN: begin
                if (tick_1hz) begin
                    if (sec_wrap_s) begin
                        sec_d = {SEC_W{1'b0}};
                        if (min_wrap_s) begin
                            min_d      = {MIN_W{1'b0}};
                            rollover_d = 1'b1;
                        end else begin
                            min_d = min_q + MIN_W'(1);
                        end
                    end else begin
                        sec_d = sec_q + SEC_W'(1);
                    end
                end else begin
                    sec_d = sec_q;
                end
            end
            ST_ADJ: begin
                // Only the selected field moves; no carry between fields.
                if (tick_2hz) begin
                    if (sel) begin
                        sec_d = sec_wrap_s ? {SEC_W{1'b0}} : sec_q + SEC_W'(1);
                    end else begin
                        min_d = min_wrap_s ? {MIN_W{1'b0}} : min_q + MIN_W'(1);
                    end
                end else begin
                    sec_d = sec_q;
                end
            end
            default: begin
                min_d = min_q;
                sec_d = sec_q;
            end
        endcase

        // Phase is zero outside ADJ and on the first ADJ cycle.
        if ((state_q == ST_ADJ) && (state_d == ST_ADJ)) begin
            blink_d = blink_q ^ tick_blink;
        end else begin
            blink_d = 1'b0;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_RUN;
            min_q        <= {MIN_W{1'b0}};
            sec_q        <= {SEC_W{1'b0}};
            rollover_q   <= 1'b0;
            pause_prev_q <= 1'b0;
            paused_q     <= 1'b0;
            blink_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            min_q        <= min_d;
            sec_q        <= sec_d;
            rollover_q   <= rollover_d;
            pause_prev_q <= pause_prev_d;
            paused_q     <= paused_d;
            blink_q      <= blink_d;
        end
    end

    assign minutes   = min_q;
    assign seconds   = sec_q;
    assign rollover  = rollover_q;
    assign mode      = state_q;
    assign blank_min = (state_q == ST_ADJ) & ~sel & blink_q;
    assign blank_sec = (state_q == ST_ADJ) &  sel & blink_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: time-of-day style model compared
// every cycle, plus literal expectations for the key scenarios.
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_1hz = 1'b0, tick_2hz = 1'b0, tick_blink = 1'b0;
    logic       sel = 1'b0, adj = 1'b0, pause = 1'b0;
    logic [6:0] minutes;
    logic [5:0] seconds;
    logic       blank_min, blank_sec, rollover;
    logic [1:0] mode;

    int n_pass = 0;
    int n_total = 0;

    // model state: mode 0 RUN, 1 HOLD, 2 ADJ
    int m_min, m_sec, m_mode;
    bit m_paused, m_prev, m_blink, m_roll;

    stopwatch_ctrl #(.MIN_MAX(99), .MIN_W(7), .SEC_MAX(59), .SEC_W(6)) dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
        .tick_blink(tick_blink), .sel(sel), .adj(adj), .pause(pause),
        .minutes(minutes), .seconds(seconds), .blank_min(blank_min),
        .blank_sec(blank_sec), .rollover(rollover), .mode(mode)
    );

    always #5 clk = ~clk;

    task automatic mdl_reset();
        m_min = 0; m_sec = 0; m_mode = 0;
        m_paused = 0; m_prev = 0; m_blink = 0; m_roll = 0;
    endtask

    task automatic mdl_step(input bit t1, input bit t2, input bit tb);
        int tot;
        int new_mode;
        bit rise;
        if (rst) begin
            mdl_reset();
        end else begin
            rise     = pause && !m_prev;
            new_mode = m_paused ? 1 : (adj ? 2 : 0);
            m_roll   = 0;
            if (m_mode == 0 && t1) begin
                tot    = m_min * 60 + m_sec;
                m_roll = (tot == 100 * 60 - 1);
                tot    = (tot + 1) % (100 * 60);
                m_min  = tot / 60;
                m_sec  = tot % 60;
            end else if (m_mode == 2 && t2) begin
                if (sel) m_sec = (m_sec + 1) % 60;
                else     m_min = (m_min + 1) % 100;
            end
            m_blink  = (m_mode == 2 && new_mode == 2) ? (m_blink ^ tb) : 1'b0;
            m_paused = m_paused ^ rise;
            m_prev   = pause;
            m_mode   = new_mode;
        end
    endtask

    task automatic compare_model();
        bit exp_bm, exp_bs;
        exp_bm = (m_mode == 2) && !sel && m_blink;
        exp_bs = (m_mode == 2) && sel && m_blink;
        n_total++;
        if (minutes == 7'(m_min) && seconds == 6'(m_sec) && mode == 2'(m_mode) &&
            rollover == m_roll && blank_min == exp_bm && blank_sec == exp_bs) begin
            n_pass++;
        end else begin
            $display("FAIL model t=%0t got %0d:%0d mode=%0d roll=%0b bm=%0b bs=%0b required %0d:%0d mode=%0d roll=%0b bm=%0b bs=%0b",
                     $time, minutes, seconds, mode, rollover, blank_min, blank_sec,
                     m_min, m_sec, m_mode, m_roll, exp_bm, exp_bs);
        end
    endtask

    task automatic check_lit(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got %0d required %0d", name, got, exp);
    endtask

    task automatic cyc(input bit t1, input bit t2, input bit tb);
        tick_1hz = t1; tick_2hz = t2; tick_blink = tb;
        @(posedge clk);
        mdl_step(t1, t2, tb);
        #1;
        compare_model();
        tick_1hz = 1'b0; tick_2hz = 1'b0; tick_blink = 1'b0;
    endtask

    task automatic set_time(input int m, input int s);
        adj = 1'b1;
        cyc(0, 0, 0); cyc(0, 0, 0);
        sel = 1'b0;
        repeat ((m - m_min + 100) % 100) cyc(0, 1, 0);
        sel = 1'b1;
        repeat ((s - m_sec + 60) % 60) cyc(0, 1, 0);
        adj = 1'b0;
        cyc(0, 0, 0); cyc(0, 0, 0);
    endtask

    initial begin
        mdl_reset();
        #1;
        check_lit("reset_min", minutes, 0);
        check_lit("reset_mode", mode, 0);
        check_lit("reset_roll", rollover, 0);
        cyc(0, 0, 0); cyc(1, 0, 0);
        rst = 1'b0;
        cyc(0, 0, 0);

        // 00:58 -> 00:59 -> 01:00, no rollover
        set_time(0, 58);
        cyc(1, 0, 0);
        check_lit("run_0059_sec", seconds, 59);
        cyc(1, 0, 0);
        check_lit("run_0100_min", minutes, 1);
        check_lit("run_0100_sec", seconds, 0);
        check_lit("run_0100_roll", rollover, 0);

        // 99:59 -> 00:00 with single-cycle rollover
        set_time(99, 59);
        cyc(1, 0, 0);
        check_lit("wrap_min", minutes, 0);
        check_lit("wrap_roll", rollover, 1);
        cyc(0, 0, 0);
        check_lit("wrap_roll_drop", rollover, 0);

        // pause at 05:10, ticks ignored, resume
        set_time(5, 10);
        pause = 1'b1; cyc(0, 0, 0);
        pause = 1'b0; cyc(0, 0, 0);
        repeat (10) cyc(1, 0, 0);
        check_lit("hold_mode", mode, 1);
        check_lit("hold_min", minutes, 5);
        check_lit("hold_sec", seconds, 10);
        pause = 1'b1; cyc(0, 0, 0);
        pause = 1'b0; cyc(0, 0, 0);
        check_lit("resume_mode", mode, 0);
        cyc(1, 0, 0);
        check_lit("resume_sec", seconds, 11);

        // ADJ seconds at 03:59: no carry, tick_1hz ignored, blink on seconds
        set_time(3, 59);
        adj = 1'b1; sel = 1'b1;
        cyc(0, 0, 0); cyc(0, 0, 0);
        check_lit("adj_mode", mode, 2);
        cyc(1, 1, 0);
        check_lit("adj_min", minutes, 3);
        check_lit("adj_sec", seconds, 0);
        cyc(0, 0, 1);
        check_lit("blink1_sec", blank_sec, 1);
        check_lit("blink1_min", blank_min, 0);
        cyc(0, 0, 1);
        check_lit("blink2_sec", blank_sec, 0);
        cyc(0, 0, 1);
        check_lit("blink3_sec", blank_sec, 1);
        check_lit("blink3_min", blank_min, 0);
        sel = 1'b0; #1;
        check_lit("sel_move_min", blank_min, 1);
        check_lit("sel_move_sec", blank_sec, 0);
        cyc(0, 1, 0);
        sel = 1'b1;
        cyc(0, 0, 0);

        // pause edge while in ADJ -> HOLD with blanks off
        pause = 1'b1; cyc(0, 0, 1);
        pause = 1'b0; cyc(0, 0, 1);
        check_lit("adjpause_mode", mode, 1);
        check_lit("adjpause_bs", blank_sec, 0);
        check_lit("adjpause_bm", blank_min, 0);
        pause = 1'b1; cyc(0, 0, 0);
        pause = 1'b0; cyc(0, 0, 0);

        // reset mid-ADJ at 12:34, pause held through reset release
        set_time(12, 34);
        adj = 1'b1;
        cyc(0, 0, 0); cyc(0, 0, 1);
        check_lit("pre_rst_mode", mode, 2);
        rst = 1'b1;
        mdl_reset();
        #1;
        check_lit("arst_min", minutes, 0);
        check_lit("arst_sec", seconds, 0);
        check_lit("arst_mode", mode, 0);
        check_lit("arst_blank", {blank_min, blank_sec, rollover}, 0);
        pause = 1'b1;
        cyc(0, 0, 0);
        rst = 1'b0;
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        check_lit("post_rst_hold", mode, 1);
        pause = 1'b0;
        repeat (3) cyc(1, 1, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 The block SHALL expose these parameters:
- MIN_MAX, 99: largest minutes value; minutes wrap to 0 after it.
- MIN_W, 7: minutes output width, at least clog2(MIN_MAX+1).
- SEC_MAX, 59: largest seconds value.
- SEC_W, 6: seconds output width.

REQ-002 The block SHALL have one clock and an asynchronous, active-high reset, with these ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous active-high reset.
- tick_1hz  in  1  one-clk-wide enable pulse, run-mode count rate.
- tick_2hz  in  1  one-clk-wide enable pulse, adjust-mode count rate.
- tick_blink  in  1  one-clk-wide enable pulse, blink toggle rate.
- sel  in  1  adjust field select: 0 = minutes, 1 = seconds.
- adj  in  1  level; 1 requests adjust mode.
- pause  in  1  level button; each rising edge toggles the pause latch.
- minutes  out  MIN_W  current minutes, binary.
- seconds  out  SEC_W  current seconds, binary.
- blank_min  out  1  1 = display shall blank the minutes digits.
- blank_sec  out  1  1 = display shall blank the seconds digits.
- rollover  out  1  one-clk pulse when minutes wrap MIN_MAX->0 in run mode.
- mode  out  2  state code: 00 RUN, 01 HOLD, 10 ADJ.

REQ-003 sel, adj and pause SHALL be treated as synchronous, debounced levels; no internal synchronisers.

Function
REQ-004 The pause edge detector SHALL register pause each clk; a rising edge is pause=1 with the registered value 0.

REQ-005 paused_q SHALL toggle on every detected rising edge, in every state.

REQ-006 The state register SHALL be updated each clk with next state = HOLD if paused_q is 1, else ADJ if adj is 1, else RUN. Pause has priority over adjust.

REQ-007 A change on pause or adj SHALL alter counting behaviour no earlier than the clk after the state register updates. Each cycle's action uses the registered state at the start of that cycle.

REQ-008 In RUN, on tick_1hz:
- seconds SHALL increment, and wrap SEC_MAX->0 with a carry into minutes.
- minutes SHALL increment on the carry, and wrap MIN_MAX->0.
- rollover SHALL assert for exactly that clk when both fields wrap.

REQ-009 In ADJ, on tick_2hz, only the field chosen by sel SHALL increment by 1 and wrap at its maximum. There SHALL be no carry into the other field and no rollover.

REQ-010 In ADJ, tick_1hz SHALL be ignored, including when it coincides with tick_2hz.

REQ-011 In HOLD, minutes and seconds SHALL hold, all ticks SHALL be ignored, and rollover SHALL be 0.

REQ-012 Blink phase:
- In ADJ, blink_ph SHALL toggle on each tick_blink.
- In any other state, blink_ph SHALL be forced to 0.
- On entry to ADJ, blink_ph SHALL start at 0.

REQ-013 Blank outputs:
- blank_min SHALL = (state==ADJ) AND sel==0 AND blink_ph.
- blank_sec SHALL = (state==ADJ) AND sel==1 AND blink_ph.
- Both are combinational from registered state.

REQ-014 If sel changes during ADJ, the blank SHALL move to the newly selected field in the same cycle, with blink_ph kept.

REQ-015 minutes, seconds, mode and rollover SHALL be registered outputs.

REQ-016 Counters SHALL never hold values above MIN_MAX or SEC_MAX.

Reset
REQ-017 While rst=1, asynchronously:
- minutes=0, seconds=0, rollover=0, blank_min=0, blank_sec=0.
- mode=RUN, paused_q=0, blink_ph=0, pause edge register=0.

REQ-018 rst asserted mid-operation SHALL abort any mode; the first clk after deassertion evaluates from the reset state.

REQ-019 A pause held high through reset deassertion SHALL count as a rising edge on the first clk after reset.

Verification
REQ-020 Run from 00:58, two tick_1hz -> 00:59, then 01:00; rollover stays 0.

REQ-021 Run from 99:59, one tick_1hz -> 00:00 with rollover=1 for exactly one clk.

REQ-022 Pause edge during run at 05:10, then ten tick_1hz -> holds at 05:10 with mode=01. A second pause edge -> mode=00 and counting resumes.

REQ-023 adj=1, sel=1, at 03:59, one tick_2hz with simultaneous tick_1hz -> 03:00 (no carry). tick_blink pulses -> blank_sec toggles 1,0,1 and blank_min stays 0.

REQ-024 adj=1 and a pause edge in the same clk -> mode=01 (HOLD), blanks 0. Then rst pulsed mid-ADJ at 12:34 -> 00:00, mode=00, all outputs 0.
